// File: rtl/alu_cc_unit.sv
// alu_cc_unit: single-issue ALU with a condition-code register.
//   Single-cycle ops (ADD/SUB/AND/XOR/OR) deliver a result one cycle after accept.
//   Shifts (SHL/SHR/SAR) move one bit per cycle, so they deliver n+1 cycles after accept.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       request handshake; op, set_cc, a, b are captured on accept
//   out_valid/out_ready     result handshake; y, error, carry are held while stalled
//   cc_zf, cc_sf, cc_of     condition codes, updated when a result with set_cc loads
module alu_cc_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             set_cc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             error,
    output logic             carry,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_OUT} state_t;

    state_t           r_state, w_next;
    logic             r_rst_done;
    logic [WIDTH-1:0] r_y, r_sh;
    logic             r_error, r_carry, r_zf, r_sf, r_of;
    logic [SHW-1:0]   r_cnt;
    logic [2:0]       r_op;
    logic             r_set_cc;

    logic             w_accept, w_is_shift, w_shift_go;
    logic [SHW-1:0]   w_n;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_imm_y, w_step_y, w_ld_y;
    logic             w_imm_err, w_imm_carry, w_step_out;
    logic             w_ld_imm, w_ld_shift, w_ld, w_ld_err, w_ld_carry, w_ld_cc;

    assign w_accept   = in_valid && in_ready;
    assign w_n        = b[SHW-1:0];
    assign w_is_shift = op[2] && (op[1] || op[0]);
    // A zero shift amount completes like a single-cycle op with y = a.
    assign w_shift_go = w_is_shift && (w_n != '0);
    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_diff     = {1'b0, a} - {1'b0, b};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_OUT: begin
                if (w_accept) begin
                    w_next = w_shift_go ? S_SHIFT : S_OUT;
                end else if (r_state == S_IDLE || out_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_next = S_OUT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic; r_rst_done keeps in_ready low until the first edge after reset release
    always_comb begin
        out_valid = (r_state == S_OUT);
        in_ready  = r_rst_done && ((r_state == S_IDLE) || ((r_state == S_OUT) && out_ready));
    end

    // Single-cycle results
    always_comb begin
        w_imm_y     = a;
        w_imm_err   = 1'b0;
        w_imm_carry = 1'b0;
        case (op)
            OP_ADD: begin
                w_imm_y     = w_sum[WIDTH-1:0];
                w_imm_err   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                w_imm_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_imm_y     = w_diff[WIDTH-1:0];
                w_imm_err   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
                w_imm_carry = w_diff[WIDTH];   // borrow: unsigned a < b
            end
            OP_AND:  w_imm_y = a & b;
            OP_XOR:  w_imm_y = a ^ b;
            OP_OR:   w_imm_y = a | b;
            default: w_imm_y = a;
        endcase
    end

    // One shift step
    always_comb begin
        case (r_op)
            OP_SHL: begin
                w_step_y   = {r_sh[WIDTH-2:0], 1'b0};
                w_step_out = r_sh[WIDTH-1];
            end
            OP_SHR: begin
                w_step_y   = {1'b0, r_sh[WIDTH-1:1]};
                w_step_out = r_sh[0];
            end
            default: begin
                w_step_y   = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
                w_step_out = r_sh[0];
            end
        endcase
    end

    // Result load: either straight from the accept or from the final shift step
    always_comb begin
        w_ld_imm   = w_accept && !w_shift_go;
        w_ld_shift = (r_state == S_SHIFT) && (r_cnt == SHW'(1));
        w_ld       = w_ld_imm || w_ld_shift;
        w_ld_y     = w_ld_shift ? w_step_y   : w_imm_y;
        w_ld_err   = w_ld_shift ? 1'b0       : w_imm_err;
        w_ld_carry = w_ld_shift ? w_step_out : w_imm_carry;
        w_ld_cc    = w_ld_shift ? r_set_cc   : set_cc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
            r_y        <= '0;
            r_error    <= 1'b0;
            r_carry    <= 1'b0;
            r_zf       <= 1'b1;
            r_sf       <= 1'b0;
            r_of       <= 1'b0;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_set_cc   <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept && w_shift_go) begin
                r_sh     <= a;
                r_cnt    <= w_n;
                r_op     <= op;
                r_set_cc <= set_cc;
            end else if (r_state == S_SHIFT) begin
                r_sh  <= w_step_y;
                r_cnt <= r_cnt - SHW'(1);
            end
            if (w_ld) begin
                r_y     <= w_ld_y;
                r_error <= w_ld_err;
                r_carry <= w_ld_carry;
                if (w_ld_cc) begin
                    r_zf <= (w_ld_y == '0);
                    r_sf <= w_ld_y[WIDTH-1];
                    r_of <= w_ld_err;
                end
            end
        end
    end

    assign y     = r_y;
    assign error = r_error;
    assign carry = r_carry;
    assign cc_zf = r_zf;
    assign cc_sf = r_sf;
    assign cc_of = r_of;

endmodule

// File: tb/tb_alu_cc_unit.sv
// Testbench for alu_cc_unit: a 64-bit and an 8-bit instance share operand buses.
// Expected results come from a behavioural model, are queued at accept and
// compared when the matching DUT hands its result over.
module tb_alu_cc_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op;
    logic        set_cc;
    logic [63:0] a, b;
    logic        ordy;
    logic        iv[2];
    logic        rdy[2], vld[2], err_o[2], car_o[2], zf_o[2], sf_o[2], of_o[2];
    logic [63:0] y64;
    logic [7:0]  y8;
    logic [63:0] ys[2];

    always #5 clk = ~clk;

    assign ys[0] = y64;
    assign ys[1] = {56'd0, y8};

    alu_cc_unit #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .op(op),
        .set_cc(set_cc), .a(a), .b(b), .out_valid(vld[0]), .out_ready(ordy),
        .y(y64), .error(err_o[0]), .carry(car_o[0]),
        .cc_zf(zf_o[0]), .cc_sf(sf_o[0]), .cc_of(of_o[0])
    );

    alu_cc_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .op(op),
        .set_cc(set_cc), .a(a[7:0]), .b(b[7:0]), .out_valid(vld[1]), .out_ready(ordy),
        .y(y8), .error(err_o[1]), .carry(car_o[1]),
        .cc_zf(zf_o[1]), .cc_sf(sf_o[1]), .cc_of(of_o[1])
    );

    typedef struct {
        int          d;
        logic [63:0] y;
        logic        err, carry, zf, sf, of;
        int unsigned lat, acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    bit          seen;
    logic        m_zf[2], m_sf[2], m_of[2];
    int unsigned n_chk = 0, n_fail = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int d, input logic [2:0] o,
                                   input logic [63:0] av, input logic [63:0] bv);
        exp_t               e;
        int unsigned        w, n;
        logic [63:0]        mask, ax;
        logic [64:0]        s;
        logic signed [63:0] sx;
        w    = (d == 0) ? 64 : 8;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        n    = 32'(bv & 64'(w - 1));
        e    = '{default: 0};
        e.d  = d;
        e.lat = 1;
        case (o)
            3'd0: begin
                s      = {1'b0, av} + {1'b0, bv};
                e.y    = s[63:0] & mask;
                e.carry = s[w];
                e.err  = (av[w-1] == bv[w-1]) && (e.y[w-1] != av[w-1]);
            end
            3'd1: begin
                e.y    = (av - bv) & mask;
                e.carry = (av < bv);
                e.err  = (av[w-1] != bv[w-1]) && (e.y[w-1] != av[w-1]);
            end
            3'd2: e.y = av & bv;
            3'd3: e.y = av ^ bv;
            3'd4: e.y = av | bv;
            default: begin
                if (n == 0) begin
                    e.y = av;
                end else begin
                    e.lat = n + 1;
                    if (o == 3'd5) begin
                        e.y = (av << n) & mask;
                        e.carry = av[w-n];
                    end else if (o == 3'd6) begin
                        e.y = av >> n;
                        e.carry = av[n-1];
                    end else begin
                        ax = av | (av[w-1] ? ~mask : 64'd0);
                        sx = ax;
                        e.y = 64'(sx >>> n) & mask;
                        e.carry = av[n-1];
                    end
                end
            end
        endcase
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic drive(input int d, input logic [2:0] o, input logic [63:0] av,
                         input logic [63:0] bv, input logic sc);
        exp_t        e;
        int unsigned waited = 0;
        logic [63:0] mask;
        mask = (d == 0) ? '1 : 64'hFF;
        op = o; a = av; b = bv; set_cc = sc; iv[d] = 1'b1;
        @(negedge clk);
        while (!rdy[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[d]) begin
            check("accept_timeout", rdy[d], 1);
            iv[d] = 1'b0;
            return;
        end
        e = model(d, o, av & mask, bv & mask);
        if (sc) begin
            m_zf[d] = (e.y == 64'd0);
            m_sf[d] = e.y[(d == 0) ? 63 : 7];
            m_of[d] = e.err;
        end
        e.zf  = m_zf[d];
        e.sf  = m_sf[d];
        e.of  = m_of[d];
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    task automatic drain();
        int unsigned w = 0;
        while (sb.size() > 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (vld[d]) begin
                    if (sb.size() == 0 || sb[0].d != d) begin
                        check($sformatf("unexpected_valid%0d", d), vld[d], 0);
                    end else begin
                        if (!seen) begin
                            check($sformatf("latency%0d", d), cyc, sb[0].acc + sb[0].lat - 1);
                            seen = 1'b1;
                        end
                        if (ordy) begin
                            m_e = sb.pop_front();
                            seen = 1'b0;
                            check($sformatf("y%0d", d), ys[d], m_e.y);
                            check($sformatf("error%0d", d), err_o[d], m_e.err);
                            check($sformatf("carry%0d", d), car_o[d], m_e.carry);
                            check($sformatf("cc_zf%0d", d), zf_o[d], m_e.zf);
                            check($sformatf("cc_sf%0d", d), sf_o[d], m_e.sf);
                            check($sformatf("cc_of%0d", d), of_o[d], m_e.of);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  o;
        int unsigned c0;
        ordy = 1'b1; iv[0] = 1'b0; iv[1] = 1'b0;
        op = '0; a = '0; b = '0; set_cc = 1'b0; seen = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_zf[d] = 1'b1; m_sf[d] = 1'b0; m_of[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", vld[d], 0);
            check("rst_y", ys[d], 0);
            check("rst_error", err_o[d], 0);
            check("rst_carry", car_o[d], 0);
            check("rst_zf", zf_o[d], 1);
            check("rst_sf", sf_o[d], 0);
            check("rst_of", of_o[d], 0);
            check("rst_ready", rdy[d], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check("ready_at_release", rdy[0], 0);
        @(posedge clk); #1;
        check("ready_after_edge0", rdy[0], 1);
        check("ready_after_edge1", rdy[1], 1);

        drive(0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        drive(0, 3'd1, 64'd5, 64'd5, 1'b1);
        drive(0, 3'd1, 64'd3, 64'd5, 1'b0);
        drain();

        drive(0, 3'd7, 64'h8000_0000_0000_0000, 64'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("sar_busy", rdy[0], 0);
            @(posedge clk); #1;
        end
        drain();
        drive(0, 3'd6, 64'hCAFE_0000_0000_0001, 64'd64, 1'b0);
        drive(0, 3'd5, 64'h8000_0000_0000_0001, 64'd1, 1'b1);
        drain();

        drive(0, 3'd6, 64'hDEAD_BEEF_0000_0000, 64'd63, 1'b1);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("shift_busy", rdy[0], 0);
        rst_n = 1'b0;
        sb.delete();
        seen = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_zf[d] = 1'b1; m_sf[d] = 1'b0; m_of[d] = 1'b0;
        end
        #1;
        check("midrst_valid", vld[0], 0);
        check("midrst_y", ys[0], 0);
        check("midrst_zf", zf_o[0], 1);
        check("midrst_sf", sf_o[0], 0);
        check("midrst_of", of_o[0], 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midrst_ready", rdy[0], 0);
        rst_n = 1'b1;
        #1 check("midrst_ready_release", rdy[0], 0);
        @(posedge clk); #1;
        check("midrst_ready_edge", rdy[0], 1);
        repeat (70) begin
            @(posedge clk); #1;
        end
        check("midrst_no_valid", vld[0], 0);

        drive(0, 3'd3, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", vld[0], 1);
            check("bp_y", ys[0], 64'h1D3B_5977_95B3_D1FF);
            check("bp_ready", rdy[0], 0);
        end
        @(posedge clk); #1;
        ordy = 1'b1;
        c0 = cyc;
        drive(0, 3'd2, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b1);
        check("bp_accept_cycle", cyc, c0 + 1);
        drain();

        drive(1, 3'd0, 64'hFF, 64'h01, 1'b1);
        drive(1, 3'd5, 64'h35, 64'h0B, 1'b1);
        for (int i = 0; i < 10; i++) begin
            o = 3'($urandom_range(0, 7));
            drive(1, o, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            drive(0, o, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cc_unit.md
ALU_CC_UNIT -- requirements
Module: alu_cc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; power of two, 8..64.
REQ-002 SHALL derive SHW = log2(WIDTH), the shift-amount width; not overridable.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port op  input  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SHL, 110 SHR, 111 SAR.
REQ-008 SHALL have port set_cc  input  1  update condition codes with this result.
REQ-009 SHALL have ports a, b  input  WIDTH  signed operands.
REQ-010 SHALL have port out_valid  output  1  result held in y/error/carry.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port y  output  WIDTH  registered result.
REQ-013 SHALL have ports error, carry  output  1  signed overflow, carry/borrow/shift-out.
REQ-014 SHALL have ports cc_zf, cc_sf, cc_of  output  1  condition-code register.

Function
REQ-015 SHALL capture op, a, b, set_cc on a cycle with in_valid && in_ready (accept).
REQ-016 SHALL implement FSM states IDLE, SHIFT, OUT; in_ready = (IDLE) or (OUT && out_ready).
REQ-017 SHALL, for ADD/SUB/AND/XOR/OR, load y/error/carry and enter OUT on the edge ending the accept cycle (latency 1).
REQ-018 SHALL compute ADD y=a+b, SUB y=a-b mod 2^WIDTH; error = signed overflow; ADD carry = unsigned carry-out; SUB carry = 1 iff unsigned a < b.
REQ-019 SHALL force error=0, carry=0 for AND, XOR, OR.
REQ-020 SHALL use n = b[SHW-1:0] as shift amount; upper bits of b ignored.
REQ-021 SHALL shift iteratively one bit per cycle in SHIFT for n cycles, then enter OUT (latency n+1); n=0 goes directly to OUT with y=a, carry=0 (latency 1).
REQ-022 SHALL set carry for shifts = last bit shifted out; SHL/SHR fill 0, SAR fills a[WIDTH-1]; error=0.
REQ-023 SHALL hold in_ready=0 throughout SHIFT and ignore in_valid.
REQ-024 SHALL assert out_valid only in OUT; y/error/carry stable while out_valid && !out_ready.
REQ-025 SHALL, in OUT with out_ready=1: go IDLE if no accept, else process the new request same edge (back-to-back, one result per cycle for non-shift ops).
REQ-026 SHALL update cc_zf=(y==0), cc_sf=y[WIDTH-1], cc_of=error on the same edge the result loads, only if captured set_cc=1; else hold.
REQ-027 SHALL leave CC unchanged by results never loaded (aborted by reset).

Reset
REQ-028 SHALL, on rst_n low, immediately force state IDLE, out_valid=0, y=0, error=0, carry=0, cc_zf=1, cc_sf=0, cc_of=0.
REQ-029 SHALL, with rst_n low, hold in_ready=0; in_ready=1 from first clk edge after release.
REQ-030 SHALL abandon any in-flight shift or undelivered result on reset; no out_valid afterwards for it.

Verification (WIDTH=64 unless stated)
REQ-031 SHALL test ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 -> out_valid 1 cycle after accept, y=0x8000_0000_0000_0000, error=1, carry=0, CC Z0 S1 O1.
REQ-032 SHALL test SUB 5-5 set_cc=1 then SUB 3-5 set_cc=0 -> y=0 carry=0 ZF=1; then y=0xFFFF_FFFF_FFFF_FFFE carry=1, CC still Z1 S0 O0.
REQ-033 SHALL test SAR a=0x8000_0000_0000_0000 b=4 -> in_ready=0 4 cycles, out_valid 5 cycles after accept, y=0xF800_0000_0000_0000, carry=0; SHL a=0x8000_0000_0000_0001 b=1 -> y=2, carry=1, latency 2.
REQ-034 SHALL test backpressure: out_ready=0 for 3 cycles -> y/out_valid held, in_ready=0; then out_ready=1 with in_valid=1 (AND) -> accepted same cycle, new result next cycle.
REQ-035 SHALL test reset mid-shift: SHR b=63, rst_n low 10 cycles after accept -> out_valid=0, y=0, CC Z1 S0 O0, in_ready=1 after release.
REQ-036 SHALL test WIDTH=8 instance: ADD 0xFF+0x01 -> y=0x00, carry=1, error=0, ZF=1; SHL b=0x0B -> shift by 3.
